adc_serial_responder: RTL and testbench

Clocked emulator of the load-circuit serial ADCs: the responder end of the CS / ADC_clk / DATA serial link that the ADC capture logic drives as initiator. It takes parallel 8-bit samples per channel, watches the chip-select and serial clock produced by the capture logic, and shifts each sample out MSB-first on one data line per channel. This lets the full acquisition path (ADC capture → sample store → Nios readout) be exercised in loopback without the load circuit. The top level instantiates it twice: once for the voltage group, once for the current group.

---
 rtl/adc_serial_responder_pkg.sv | 16 +
 rtl/adc_serial_responder_edge_sync.sv | 37 +++
 rtl/adc_serial_responder.sv | 136 +++++++++++++
 tb/tb_adc_serial_responder.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/adc_serial_responder_pkg.sv
// Frame constants and FSM encoding shared by the serial ADC responder and the
// ADC capture block that drives it.
package adc_serial_responder_pkg;

    localparam int CHANNELS_DEF = 3;
    localparam int WIDTH_DEF    = 8;
    localparam int LEAD_BITS    = 3;
    localparam int FRAME_BITS   = 16;
    localparam int SYNC_STAGES  = 2;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/adc_serial_responder_edge_sync.sv
// Pin synchronizer with rise/fall pulses; valid_o marks when the chain holds
// real pin samples rather than its reset level.
module adc_serial_responder_edge_sync #(
    parameter int   STAGES    = 2,
    parameter logic RST_LEVEL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic level_o,
    output logic valid_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] fill_q;
    logic              last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RST_LEVEL}};
            fill_q <= '0;
            last_q <= RST_LEVEL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            fill_q <= {fill_q[STAGES-2:0], 1'b1};
            last_q <= sync_q[STAGES-1];
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign valid_o = fill_q[STAGES-1];
    assign rise_o  = sync_q[STAGES-1] & ~last_q;
    assign fall_o  = ~sync_q[STAGES-1] & last_q;

endmodule

// File: rtl/adc_serial_responder.sv
// Responder end of the CS / ADC_clk / DATA link: shifts a captured parallel
// sample out MSB-first per channel, after LEAD_BITS zeros.
//   state | meaning
//   IDLE  | waiting for CS fall while armed; data lines held low
//   SHIFT | frame in progress; one bit position per adc_clk fall
module adc_serial_responder
    import adc_serial_responder_pkg::*;
#(
    parameter int CHANNELS = CHANNELS_DEF,
    parameter int WIDTH    = WIDTH_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      adc_clk_in,
    input  logic                      cs_in,
    input  logic [CHANNELS*WIDTH-1:0] sample_in,
    output logic [CHANNELS-1:0]       data_out,
    output logic                      sample_taken,
    output logic                      frame_done,
    output logic                      frame_abort,
    output logic [15:0]               frame_count
);

    localparam int CNT_W = $clog2(FRAME_BITS + 1);

    logic cs_level, cs_valid, cs_rise, cs_fall;
    logic adc_valid, adc_fall, adc_rise_unused, adc_level_unused;

    adc_serial_responder_edge_sync #(.STAGES(SYNC_STAGES), .RST_LEVEL(1'b1)) u_cs_sync (
        .clk(clk), .rst_n(reset), .d_i(cs_in),
        .level_o(cs_level), .valid_o(cs_valid), .rise_o(cs_rise), .fall_o(cs_fall)
    );

    adc_serial_responder_edge_sync #(.STAGES(SYNC_STAGES), .RST_LEVEL(1'b1)) u_adc_sync (
        .clk(clk), .rst_n(reset), .d_i(adc_clk_in),
        .level_o(adc_level_unused), .valid_o(adc_valid), .rise_o(adc_rise_unused), .fall_o(adc_fall)
    );

    state_e                    state_q, state_d;
    logic [CNT_W-1:0]          bit_cnt_q, bit_cnt_d, bit_cnt_inc;
    logic [CHANNELS*WIDTH-1:0] shadow_q, shadow_d;
    logic [CHANNELS-1:0]       data_q, data_d;
    logic                      armed_q, armed_d;
    logic                      taken_q, taken_d, done_q, done_d, abort_q, abort_d;
    logic [15:0]               count_q, count_d;

    function automatic logic [CHANNELS-1:0] bits_at(input logic [CHANNELS*WIDTH-1:0] sh,
                                                    input logic [CNT_W-1:0] cnt);
        logic [CHANNELS-1:0] r;
        r = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            for (int b = 0; b < WIDTH; b++) begin
                if (cnt == CNT_W'(LEAD_BITS + WIDTH - 1 - b)) r[k] = sh[k*WIDTH + b];
            end
        end
        return r;
    endfunction

    // Arming waits for a real synchronized CS high, so a CS held low across
    // reset release cannot fake a falling edge from the reset level.
    assign armed_d     = armed_q | (cs_level & cs_valid);
    assign bit_cnt_inc = (bit_cnt_q == CNT_W'(FRAME_BITS)) ? bit_cnt_q : bit_cnt_q + CNT_W'(1);

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shadow_d  = shadow_q;
        data_d    = data_q;
        taken_d   = 1'b0;
        done_d    = 1'b0;
        abort_d   = 1'b0;
        count_d   = count_q;
        case (state_q)
            IDLE: begin
                data_d = '0;
                if (cs_fall && armed_q) begin
                    shadow_d  = sample_in;
                    taken_d   = 1'b1;
                    bit_cnt_d = '0;
                    data_d    = bits_at(sample_in, '0);
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    if (bit_cnt_q >= CNT_W'(FRAME_BITS)) begin
                        done_d  = 1'b1;
                        count_d = count_q + 16'd1;
                    end else begin
                        abort_d = 1'b1;
                    end
                    data_d  = '0;
                    state_d = IDLE;
                end else if (adc_fall && adc_valid) begin
                    bit_cnt_d = bit_cnt_inc;
                    data_d    = bits_at(shadow_q, bit_cnt_inc);
                end
            end
            default: begin
                data_d  = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shadow_q  <= '0;
            data_q    <= '0;
            armed_q   <= 1'b0;
            taken_q   <= 1'b0;
            done_q    <= 1'b0;
            abort_q   <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shadow_q  <= shadow_d;
            data_q    <= data_d;
            armed_q   <= armed_d;
            taken_q   <= taken_d;
            done_q    <= done_d;
            abort_q   <= abort_d;
            count_q   <= count_d;
        end
    end

    assign data_out     = data_q;
    assign sample_taken = taken_q;
    assign frame_done   = done_q;
    assign frame_abort  = abort_q;
    assign frame_count  = count_q;

endmodule

// File: tb/tb_adc_serial_responder.sv
// Directed plus randomized frames against a bit-position model of the serial
// ADC frame format.
module tb_adc_serial_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        adc_clk_in = 1'b1;
    logic        cs_in = 1'b1;
    logic [23:0] sample_in = '0;
    logic [2:0]  data_out;
    logic        sample_taken, frame_done, frame_abort;
    logic [15:0] frame_count;

    int checks = 0;
    int errors = 0;
    int n_st = 0, n_done = 0, n_abort = 0;
    int model_frames = 0;

    adc_serial_responder dut (
        .clk(clk), .reset(reset), .adc_clk_in(adc_clk_in), .cs_in(cs_in),
        .sample_in(sample_in), .data_out(data_out), .sample_taken(sample_taken),
        .frame_done(frame_done), .frame_abort(frame_abort), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sample_taken) n_st++;
        if (frame_done)   n_done++;
        if (frame_abort)  n_abort++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Data lines after e falling edges: zeros for the lead bits, then the
    // captured byte MSB first, then zeros for the rest of the frame.
    function automatic logic [2:0] exp_bits(input logic [23:0] s, input int e);
        logic [2:0] r;
        logic [7:0] b;
        r = '0;
        if (e >= 3 && e <= 10) begin
            for (int k = 0; k < 3; k++) begin
                b = s[k*8 +: 8];
                r[k] = b[10 - e];
            end
        end
        return r;
    endfunction

    task automatic run_frame(input logic [23:0] s, input int nfall, input bit coinc);
        int  st0, d0, a0;
        bit  done_exp;
        st0 = n_st; d0 = n_done; a0 = n_abort;
        @(negedge clk);
        sample_in = s;
        cs_in = 1'b0;
        repeat (2) @(negedge clk);
        chk("st_early", sample_taken, 0);
        @(negedge clk);
        chk("st_pulse", sample_taken, 1);
        repeat (5) @(negedge clk);
        sample_in = $urandom;
        chk("lead0", data_out, 0);
        for (int e = 1; e <= nfall; e++) begin
            adc_clk_in = 1'b0;
            repeat (2) @(negedge clk);
            chk("data_hold", data_out, exp_bits(s, e - 1));
            @(negedge clk);
            chk("data_bit", data_out, exp_bits(s, e));
            repeat (5) @(negedge clk);
            adc_clk_in = 1'b1;
            repeat (8) @(negedge clk);
        end
        if (coinc) adc_clk_in = 1'b0;
        cs_in = 1'b1;
        repeat (3) @(negedge clk);
        chk("data_idle", data_out, 0);
        repeat (5) @(negedge clk);
        adc_clk_in = 1'b1;
        repeat (8) @(negedge clk);
        done_exp = (nfall >= 16) && !coinc;
        if (done_exp) model_frames++;
        chk("st_count", n_st - st0, 1);
        chk("done_count", n_done - d0, done_exp);
        chk("abort_count", n_abort - a0, !done_exp);
        chk("frame_count", frame_count, 16'(model_frames));
    endtask

    initial begin
        int st0, a0, nf;
        repeat (3) @(negedge clk);
        chk("in_reset", {data_out, sample_taken, frame_done, frame_abort, frame_count}, 0);
        reset = 1'b1;
        repeat (6) @(negedge clk);
        chk("reset_vals", {data_out, sample_taken, frame_done, frame_abort, frame_count}, 0);

        run_frame({8'hC3, 8'h5A, 8'hFF}, 16, 1'b0);
        run_frame($urandom, 7, 1'b0);
        run_frame($urandom, 20, 1'b0);
        run_frame($urandom, 15, 1'b1);
        for (int i = 0; i < 6; i++) begin
            nf = $urandom_range(1, 20);
            run_frame($urandom, nf, 1'b0);
        end

        // CS held low across reset release must not start a frame.
        @(negedge clk);
        reset = 1'b0;
        cs_in = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        model_frames = 0;
        st0 = n_st; a0 = n_abort;
        repeat (12) @(negedge clk);
        chk("cs_low_no_take", n_st - st0, 0);
        chk("cs_low_fc", frame_count, 0);
        chk("cs_low_data", data_out, 0);
        cs_in = 1'b1;
        repeat (10) @(negedge clk);
        chk("cs_low_no_abort", n_abort - a0, 0);
        run_frame($urandom, 16, 1'b0);

        // Reset asserted mid-frame clears outputs without a clock edge.
        @(negedge clk);
        sample_in = 24'hFFFFFF;
        cs_in = 1'b0;
        repeat (8) @(negedge clk);
        for (int e = 1; e <= 4; e++) begin
            adc_clk_in = 1'b0;
            repeat (8) @(negedge clk);
            if (e < 4) begin
                adc_clk_in = 1'b1;
                repeat (8) @(negedge clk);
            end
        end
        chk("pre_reset_data", data_out, 3'b111);
        chk("pre_reset_fc", frame_count, 16'(model_frames));
        #2 reset = 1'b0;
        #1 chk("async_reset", {data_out, sample_taken, frame_done, frame_abort, frame_count}, 0);
        @(negedge clk);
        cs_in = 1'b1;
        adc_clk_in = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        model_frames = 0;
        repeat (6) @(negedge clk);
        run_frame($urandom, 16, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
